axi_lite_master_param: RTL and testbench

Parametrised AXI-lite master that converts single-beat user write and read commands into the five AXI channels. It succeeds the fixed 3-bit address / 4-bit data master. New capabilities:
- Configurable widths.
- AW/W valids held until their own ready, and accepted independently.
- 2-bit responses.
- Per-engine timeout.
- Busy/done status.

It sits between a local controller and an AXI-lite interconnect slave port.

---
 rtl/axi_lite_master_param.sv | 245 ++++++++++++++++++++++++
 tb/tb_axi_lite_master_param.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_master_param.sv
`default_nettype none
// ============================================================================
// Module : axi_lite_master_param
// Desc   : Single-beat AXI-lite master with independent write/read engines,
//          per-engine timeout and busy/done status.
// Rev    : 1.0  initial release
// ============================================================================
module axi_lite_master_param #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int STRB_W  = DATA_W / 8,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    // write command / status
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr_in,
    input  logic [DATA_W-1:0] wdata_in,
    input  logic [STRB_W-1:0] wstrb_in,
    output logic              wr_busy,
    output logic              wr_done,
    output logic [1:0]        wr_resp_out,
    output logic              wr_timeout,
    // read command / status
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr_in,
    output logic              rd_busy,
    output logic              rd_done,
    output logic [DATA_W-1:0] rdata_out,
    output logic [1:0]        rd_resp_out,
    output logic              rd_timeout,
    // AXI-lite channels
    output logic              wa_valid,
    input  logic              wa_ready,
    output logic [ADDR_W-1:0] wa_addr,
    output logic              wd_valid,
    input  logic              wd_ready,
    output logic [DATA_W-1:0] wd_data,
    output logic [STRB_W-1:0] wd_strb,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [1:0]        b_response,
    output logic              ra_valid,
    input  logic              ra_ready,
    output logic [ADDR_W-1:0] ra_addr,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [DATA_W-1:0] rdata_in,
    input  logic [1:0]        rd_response
);
    localparam int               CNT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [1:0]       c_slverr   = 2'b10;

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_REQ = 2'd1, W_RESP = 2'd2} wstate_t;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2} rstate_t;

    wstate_t           r_wstate, w_wstate_nxt;
    rstate_t           r_rstate, w_rstate_nxt;
    logic [CNT_W-1:0]  r_wcnt, w_wcnt_nxt, r_rcnt, w_rcnt_nxt;
    logic              w_wa_valid_nxt, w_wd_valid_nxt, w_b_ready_nxt;
    logic [ADDR_W-1:0] w_wa_addr_nxt, w_ra_addr_nxt;
    logic [DATA_W-1:0] w_wd_data_nxt, w_rdata_nxt;
    logic [STRB_W-1:0] w_wd_strb_nxt;
    logic [1:0]        w_wr_resp_nxt, w_rd_resp_nxt;
    logic              w_wr_done_nxt, w_wr_to_nxt, w_rd_done_nxt, w_rd_to_nxt;
    logic              w_ra_valid_nxt, w_rd_ready_nxt;
    logic              w_aw_ok, w_wd_ok, w_wexpire, w_rexpire;

    // A channel counts as finished once its valid has dropped or is handshaking now.
    assign w_aw_ok   = !wa_valid || wa_ready;
    assign w_wd_ok   = !wd_valid || wd_ready;
    assign w_wexpire = (TIMEOUT > 0) && (r_wcnt == c_cnt_last);
    assign w_rexpire = (TIMEOUT > 0) && (r_rcnt == c_cnt_last);
    assign wr_busy   = (r_wstate != W_IDLE);
    assign rd_busy   = (r_rstate != R_IDLE);

    always_comb begin
        w_wstate_nxt   = r_wstate;
        w_wcnt_nxt     = r_wcnt;
        w_wa_valid_nxt = wa_valid;
        w_wd_valid_nxt = wd_valid;
        w_b_ready_nxt  = b_ready;
        w_wa_addr_nxt  = wa_addr;
        w_wd_data_nxt  = wd_data;
        w_wd_strb_nxt  = wd_strb;
        w_wr_resp_nxt  = wr_resp_out;
        w_wr_done_nxt  = 1'b0;
        w_wr_to_nxt    = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                if (wr_en) begin
                    w_wa_addr_nxt  = wr_addr_in;
                    w_wd_data_nxt  = wdata_in;
                    w_wd_strb_nxt  = wstrb_in;
                    w_wa_valid_nxt = 1'b1;
                    w_wd_valid_nxt = 1'b1;
                    w_wcnt_nxt     = '0;
                    w_wstate_nxt   = W_REQ;
                end
            end
            W_REQ: begin
                if (w_aw_ok && w_wd_ok) begin
                    w_wa_valid_nxt = 1'b0;
                    w_wd_valid_nxt = 1'b0;
                    w_b_ready_nxt  = 1'b1;
                    w_wcnt_nxt     = '0;
                    w_wstate_nxt   = W_RESP;
                end else if (w_wexpire) begin
                    w_wa_valid_nxt = 1'b0;
                    w_wd_valid_nxt = 1'b0;
                    w_wr_resp_nxt  = c_slverr;
                    w_wr_done_nxt  = 1'b1;
                    w_wr_to_nxt    = 1'b1;
                    w_wstate_nxt   = W_IDLE;
                end else begin
                    if (wa_valid && wa_ready) w_wa_valid_nxt = 1'b0;
                    if (wd_valid && wd_ready) w_wd_valid_nxt = 1'b0;
                    w_wcnt_nxt = r_wcnt + 1'b1;
                end
            end
            W_RESP: begin
                if (b_valid) begin
                    w_wr_resp_nxt = b_response;
                    w_b_ready_nxt = 1'b0;
                    w_wr_done_nxt = 1'b1;
                    w_wstate_nxt  = W_IDLE;
                end else if (w_wexpire) begin
                    w_wr_resp_nxt = c_slverr;
                    w_b_ready_nxt = 1'b0;
                    w_wr_done_nxt = 1'b1;
                    w_wr_to_nxt   = 1'b1;
                    w_wstate_nxt  = W_IDLE;
                end else begin
                    w_wcnt_nxt = r_wcnt + 1'b1;
                end
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        w_rstate_nxt   = r_rstate;
        w_rcnt_nxt     = r_rcnt;
        w_ra_valid_nxt = ra_valid;
        w_rd_ready_nxt = rd_ready;
        w_ra_addr_nxt  = ra_addr;
        w_rdata_nxt    = rdata_out;
        w_rd_resp_nxt  = rd_resp_out;
        w_rd_done_nxt  = 1'b0;
        w_rd_to_nxt    = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                if (rd_en) begin
                    w_ra_addr_nxt  = rd_addr_in;
                    w_ra_valid_nxt = 1'b1;
                    w_rcnt_nxt     = '0;
                    w_rstate_nxt   = R_ADDR;
                end
            end
            R_ADDR: begin
                if (ra_ready) begin
                    w_ra_valid_nxt = 1'b0;
                    w_rd_ready_nxt = 1'b1;
                    w_rcnt_nxt     = '0;
                    w_rstate_nxt   = R_DATA;
                end else if (w_rexpire) begin
                    w_ra_valid_nxt = 1'b0;
                    w_rd_resp_nxt  = c_slverr;
                    w_rd_done_nxt  = 1'b1;
                    w_rd_to_nxt    = 1'b1;
                    w_rstate_nxt   = R_IDLE;
                end else begin
                    w_rcnt_nxt = r_rcnt + 1'b1;
                end
            end
            R_DATA: begin
                if (rd_valid) begin
                    w_rdata_nxt    = rdata_in;
                    w_rd_resp_nxt  = rd_response;
                    w_rd_ready_nxt = 1'b0;
                    w_rd_done_nxt  = 1'b1;
                    w_rstate_nxt   = R_IDLE;
                end else if (w_rexpire) begin
                    w_rd_resp_nxt  = c_slverr;
                    w_rd_ready_nxt = 1'b0;
                    w_rd_done_nxt  = 1'b1;
                    w_rd_to_nxt    = 1'b1;
                    w_rstate_nxt   = R_IDLE;
                end else begin
                    w_rcnt_nxt = r_rcnt + 1'b1;
                end
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wstate    <= W_IDLE;
            r_wcnt      <= '0;
            wa_valid    <= 1'b0;
            wd_valid    <= 1'b0;
            b_ready     <= 1'b0;
            wa_addr     <= '0;
            wd_data     <= '0;
            wd_strb     <= '0;
            wr_resp_out <= 2'b00;
            wr_done     <= 1'b0;
            wr_timeout  <= 1'b0;
            r_rstate    <= R_IDLE;
            r_rcnt      <= '0;
            ra_valid    <= 1'b0;
            rd_ready    <= 1'b0;
            ra_addr     <= '0;
            rdata_out   <= '0;
            rd_resp_out <= 2'b00;
            rd_done     <= 1'b0;
            rd_timeout  <= 1'b0;
        end else begin
            r_wstate    <= w_wstate_nxt;
            r_wcnt      <= w_wcnt_nxt;
            wa_valid    <= w_wa_valid_nxt;
            wd_valid    <= w_wd_valid_nxt;
            b_ready     <= w_b_ready_nxt;
            wa_addr     <= w_wa_addr_nxt;
            wd_data     <= w_wd_data_nxt;
            wd_strb     <= w_wd_strb_nxt;
            wr_resp_out <= w_wr_resp_nxt;
            wr_done     <= w_wr_done_nxt;
            wr_timeout  <= w_wr_to_nxt;
            r_rstate    <= w_rstate_nxt;
            r_rcnt      <= w_rcnt_nxt;
            ra_valid    <= w_ra_valid_nxt;
            rd_ready    <= w_rd_ready_nxt;
            ra_addr     <= w_ra_addr_nxt;
            rdata_out   <= w_rdata_nxt;
            rd_resp_out <= w_rd_resp_nxt;
            rd_done     <= w_rd_done_nxt;
            rd_timeout  <= w_rd_to_nxt;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_axi_lite_master_param.sv
`default_nettype none
// ============================================================================
// Module : tb_axi_lite_master_param
// Desc   : Directed bench for axi_lite_master_param with a timestamp-based
//          transaction model checked every cycle.
// Rev    : 1.0  initial release
// ============================================================================
module tb_axi_lite_master_param;
    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 32;
    localparam int STRB_W  = 4;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic wr_en = 0, rd_en = 0;
    logic [ADDR_W-1:0] wr_addr_in = '0, rd_addr_in = '0;
    logic [DATA_W-1:0] wdata_in = '0, rdata_in = '0;
    logic [STRB_W-1:0] wstrb_in = '0;
    logic wa_ready = 0, wd_ready = 0, b_valid = 0, ra_ready = 0, rd_valid = 0;
    logic [1:0] b_response = '0, rd_response = '0;
    logic wr_busy, wr_done, wr_timeout, rd_busy, rd_done, rd_timeout;
    logic [1:0] wr_resp_out, rd_resp_out;
    logic [DATA_W-1:0] rdata_out, wd_data;
    logic wa_valid, wd_valid, b_ready, ra_valid, rd_ready;
    logic [ADDR_W-1:0] wa_addr, ra_addr;
    logic [STRB_W-1:0] wd_strb;

    axi_lite_master_param #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_addr_in(wr_addr_in), .wdata_in(wdata_in), .wstrb_in(wstrb_in),
        .wr_busy(wr_busy), .wr_done(wr_done), .wr_resp_out(wr_resp_out), .wr_timeout(wr_timeout),
        .rd_en(rd_en), .rd_addr_in(rd_addr_in), .rd_busy(rd_busy), .rd_done(rd_done),
        .rdata_out(rdata_out), .rd_resp_out(rd_resp_out), .rd_timeout(rd_timeout),
        .wa_valid(wa_valid), .wa_ready(wa_ready), .wa_addr(wa_addr),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
        .b_valid(b_valid), .b_ready(b_ready), .b_response(b_response),
        .ra_valid(ra_valid), .ra_ready(ra_ready), .ra_addr(ra_addr),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rdata_in(rdata_in), .rd_response(rd_response)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction model: each engine is described by the cycle numbers of its
    // acceptance, handshakes and end event (-1 = not yet happened).
    int w_acc = -1, w_aw = -1, w_wd = -1, w_req = -1, w_end = -1;
    int r_acc = -1, r_ar = -1, r_end = -1;
    bit w_to = 0, r_to = 0, w_act, r_act, e_wdone, e_rdone;
    logic [ADDR_W-1:0] m_waddr = '0, m_raddr = '0;
    logic [DATA_W-1:0] m_wdata = '0, m_rdata = '0;
    logic [STRB_W-1:0] m_wstrb = '0;
    logic [1:0] m_wresp = '0, m_rresp = '0;
    int aw_cnt = 0, wdone_cnt = 0, rdone_cnt = 0;

    always @(negedge clk) begin
        if (reset) begin
            check("reset_ctrl", {wr_busy, wr_done, wr_timeout, rd_busy, rd_done, rd_timeout,
                                 wa_valid, wd_valid, b_ready, ra_valid, rd_ready, wr_resp_out, rd_resp_out}, 0);
            check("reset_data", {rdata_out, wa_addr, ra_addr, wd_strb}, 0);
            check("reset_wdata", wd_data, 0);
            w_acc = -1; w_aw = -1; w_wd = -1; w_req = -1; w_end = -1; w_to = 0;
            r_acc = -1; r_ar = -1; r_end = -1; r_to = 0;
            m_wresp = '0; m_rresp = '0; m_rdata = '0;
        end else begin
            w_act   = (w_acc >= 0) && (w_end < 0);
            r_act   = (r_acc >= 0) && (r_end < 0);
            e_wdone = (w_end >= 0) && (cyc == w_end + 1);
            e_rdone = (r_end >= 0) && (cyc == r_end + 1);
            check("wr_busy", wr_busy, w_act);
            check("wa_valid", wa_valid, w_act && (w_aw < 0));
            check("wd_valid", wd_valid, w_act && (w_wd < 0));
            check("b_ready", b_ready, w_act && (w_req >= 0));
            check("wr_done", wr_done, e_wdone);
            check("wr_timeout", wr_timeout, e_wdone && w_to);
            check("wr_resp_out", wr_resp_out, m_wresp);
            if (wa_valid) check("wa_addr", wa_addr, m_waddr);
            if (wd_valid) check("wd_data_strb", {wd_data, wd_strb}, {m_wdata, m_wstrb});
            check("rd_busy", rd_busy, r_act);
            check("ra_valid", ra_valid, r_act && (r_ar < 0));
            check("rd_ready", rd_ready, r_act && (r_ar >= 0));
            check("rd_done", rd_done, e_rdone);
            check("rd_timeout", rd_timeout, e_rdone && r_to);
            check("rd_result", {rdata_out, rd_resp_out}, {m_rdata, m_rresp});
            if (ra_valid) check("ra_addr", ra_addr, m_raddr);
            if (wa_valid && wa_ready) aw_cnt++;
            if (wr_done) wdone_cnt++;
            if (rd_done) rdone_cnt++;

            if (w_act) begin
                if (w_aw < 0 && wa_ready) w_aw = cyc;
                if (w_wd < 0 && wd_ready) w_wd = cyc;
                if (w_req < 0) begin
                    if (w_aw >= 0 && w_wd >= 0) w_req = cyc;
                    else if (TIMEOUT > 0 && cyc == w_acc + TIMEOUT) begin
                        w_end = cyc; w_to = 1; m_wresp = 2'b10;
                    end
                end else if (b_valid) begin
                    w_end = cyc; w_to = 0; m_wresp = b_response;
                end else if (TIMEOUT > 0 && cyc == w_req + TIMEOUT) begin
                    w_end = cyc; w_to = 1; m_wresp = 2'b10;
                end
            end else if (wr_en) begin
                w_acc = cyc; w_aw = -1; w_wd = -1; w_req = -1; w_end = -1; w_to = 0;
                m_waddr = wr_addr_in; m_wdata = wdata_in; m_wstrb = wstrb_in;
            end

            if (r_act) begin
                if (r_ar < 0) begin
                    if (ra_ready) r_ar = cyc;
                    else if (TIMEOUT > 0 && cyc == r_acc + TIMEOUT) begin
                        r_end = cyc; r_to = 1; m_rresp = 2'b10;
                    end
                end else if (rd_valid) begin
                    r_end = cyc; r_to = 0; m_rdata = rdata_in; m_rresp = rd_response;
                end else if (TIMEOUT > 0 && cyc == r_ar + TIMEOUT) begin
                    r_end = cyc; r_to = 1; m_rresp = 2'b10;
                end
            end else if (rd_en) begin
                r_acc = cyc; r_ar = -1; r_end = -1; r_to = 0; m_raddr = rd_addr_in;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for a done pulse; returns cycles since t0, or -1 if none arrived.
    task automatic wait_done(input bit is_rd, input int t0, output int lat);
        bit seen;
        seen = 0;
        for (int k = 0; k < 64 && !seen; k++) begin
            @(negedge clk);
            if (is_rd ? rd_done : wr_done) seen = 1;
        end
        lat = seen ? (cyc - t0) : -1;
    endtask

    int t0, lat, base;

    initial begin
        repeat (3) tick();
        reset = 0;
        repeat (2) tick();

        // Basic write, all ready
        wa_ready = 1; wd_ready = 1; b_valid = 1; b_response = 2'b00;
        wr_en = 1; wr_addr_in = 8'h3C; wdata_in = 32'hDEADBEEF; wstrb_in = 4'hF;
        t0 = cyc; base = aw_cnt;
        tick(); wr_en = 0;
        wait_done(0, t0, lat);
        check("t1_latency", lat, 3);
        check("t1_resp", wr_resp_out, 2'b00);
        check("t1_aw_count", aw_cnt - base, 1);
        tick();

        // Split AW/W: W accepted at cycle 1, AW only at cycle 4
        wa_ready = 0; wd_ready = 1;
        wr_en = 1; wr_addr_in = 8'h44; wdata_in = 32'h0000A5A5; wstrb_in = 4'h3;
        t0 = cyc;
        tick(); wr_en = 0;
        tick(); wd_ready = 0;
        tick();
        @(negedge clk);
        check("t2_wa_held", {wa_valid, wa_addr}, {1'b1, 8'h44});
        check("t2_wd_dropped", wd_valid, 0);
        check("t2_b_ready_low", b_ready, 0);
        tick(); wa_ready = 1;
        wait_done(0, t0, lat);
        check("t2_latency", lat, 6);
        tick(); wd_ready = 1;

        // Read with delayed AR and error response
        ra_ready = 0; rd_valid = 1; rdata_in = 32'h12345678; rd_response = 2'b10;
        rd_en = 1; rd_addr_in = 8'h10; t0 = cyc; base = rdone_cnt;
        tick(); rd_en = 0;
        tick();
        tick(); ra_ready = 1;
        wait_done(1, t0, lat);
        check("t3_latency", lat, 5);
        check("t3_rdata", rdata_out, 32'h12345678);
        check("t3_resp", rd_resp_out, 2'b10);
        repeat (3) tick();
        check("t3_done_pulses", rdone_cnt - base, 1);

        // Write timeout in response phase
        b_valid = 0;
        wr_en = 1; wr_addr_in = 8'h50; wdata_in = 32'h11112222; wstrb_in = 4'hF; t0 = cyc;
        tick(); wr_en = 0;
        wait_done(0, t0, lat);
        check("t4_latency", lat, 18);
        check("t4_timeout_flag", {wr_timeout, wr_resp_out, b_ready}, {1'b1, 2'b10, 1'b0});
        tick();

        // Read timeout in address phase; previous rdata stays held
        ra_ready = 0;
        rd_en = 1; rd_addr_in = 8'h18; t0 = cyc;
        tick(); rd_en = 0;
        wait_done(1, t0, lat);
        check("t4r_latency", lat, 17);
        check("t4r_flags", {rd_timeout, rd_resp_out, ra_valid}, {1'b1, 2'b10, 1'b0});
        check("t4r_rdata_held", rdata_out, 32'h12345678);
        tick();

        // Handshake in the expiry cycle wins over timeout
        wr_en = 1; wr_addr_in = 8'h5A; wdata_in = 32'h33334444; t0 = cyc;
        tick(); wr_en = 0;
        repeat (16) tick();
        b_valid = 1; b_response = 2'b01;
        wait_done(0, t0, lat);
        check("t4b_latency", lat, 18);
        check("t4b_no_timeout", {wr_timeout, wr_resp_out}, {1'b0, 2'b01});
        tick(); b_response = 2'b00;

        // Concurrent write+read, second write while busy ignored
        ra_ready = 1; rd_valid = 1; rdata_in = 32'hCAFEF00D; rd_response = 2'b00;
        wr_en = 1; wr_addr_in = 8'h21; wdata_in = 32'h01020304; wstrb_in = 4'h5;
        rd_en = 1; rd_addr_in = 8'h22; t0 = cyc; base = aw_cnt;
        tick(); rd_en = 0; wr_addr_in = 8'h77; wdata_in = 32'hFFFF0000;
        tick(); wr_en = 0;
        wait_done(0, t0, lat);
        check("t5_wr_latency", lat, 3);
        check("t5_rd_same_cycle", {rd_done, rdata_out}, {1'b1, 32'hCAFEF00D});
        repeat (4) tick();
        check("t5_aw_count", aw_cnt - base, 1);

        // Reset while waiting for R data
        rd_valid = 0;
        rd_en = 1; rd_addr_in = 8'h30;
        tick(); rd_en = 0;
        tick();
        @(negedge clk);
        check("t6_in_rdata", rd_ready, 1);
        tick(); reset = 1; rd_valid = 1; rdata_in = 32'hBADBAD00; base = rdone_cnt;
        #1;
        check("t6_async_clear", {rd_ready, rd_busy, ra_valid}, 0);
        tick(); reset = 0;
        repeat (4) tick();
        check("t6_no_done", rdone_cnt - base, 0);
        check("t6_rdata_cleared", rdata_out, 0);
        rdata_in = 32'h0BADF00D; rd_response = 2'b01;
        rd_en = 1; rd_addr_in = 8'h31; t0 = cyc;
        tick(); rd_en = 0;
        wait_done(1, t0, lat);
        check("t6_fresh_latency", lat, 3);
        check("t6_fresh_result", {rdata_out, rd_resp_out}, {32'h0BADF00D, 2'b01});
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion, expected end of test");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
